// File: rtl/pipe_stage_pkg.sv
// LC-3b stage types used to size each pipe_stage instance, plus the stage's own
// occupancy encoding.
package lc3b_types;
  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    logic [3:0] aluop;
    logic       sr2mux_sel;
    logic [1:0] addr1mux_sel;
    logic [1:0] addr2mux_sel;
    logic       marmux_sel;
  } lc3b_control_word_ex;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic byte_op;
    logic indirect;
  } lc3b_control_word_mem;

  typedef struct packed {
    logic       load_regfile;
    logic [2:0] dest;
    logic [1:0] regfilemux_sel;
    logic       load_cc;
  } lc3b_control_word_wb;

  typedef struct packed {
    lc3b_word pc;
    lc3b_word sr1_data;
    lc3b_word sr2_data;
    lc3b_word imm;
  } lc3b_id_ex_payload;
endpackage

package pipe_stage_pkg;
  // Occupancy of the two-slot variant, decoded from the slot valid bits.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;
endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline entry: valid bit plus control and payload registers.
// Clearing always zeroes ctrl so an empty slot reads as a bubble.
module pipe_slot
  import pipe_stage_pkg::*;
#(
  parameter int CTRL_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  clear,
  input  logic [CTRL_WIDTH-1:0] load_ctrl,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  valid,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic [DATA_WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      if (CLEAR_DATA) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= load_ctrl;
      data  <= load_data;
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and an
// optional two-entry skid buffer that makes in_ready a pure register output.
module pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int CTRL_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter bit SKID       = 1'b1,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data
);

  if (SKID) begin : g_skid
    logic                  main_load, main_clear, skid_load, skid_clear, from_skid;
    logic                  skid_valid;
    logic [CTRL_WIDTH-1:0] skid_ctrl;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  accept, consume;
    stage_state_e          state;

    // The skid slot being occupied is the only thing that blocks upstream.
    assign in_ready = ~skid_valid;
    assign accept   = in_valid & ~skid_valid;
    assign consume  = out_valid & out_ready;

    always_comb begin
      main_load  = 1'b0;
      main_clear = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      from_skid  = 1'b0;
      state      = skid_valid ? ST_FULL : (out_valid ? ST_ONE : ST_EMPTY);
      if (flush) begin
        main_clear = 1'b1;
        skid_clear = 1'b1;
      end else begin
        case (state)
          ST_EMPTY: main_load = accept;
          ST_ONE: begin
            if (accept && !consume) skid_load = 1'b1;
            else if (accept)        main_load = 1'b1;
            else if (consume)       main_clear = 1'b1;
          end
          ST_FULL: begin
            if (consume) begin
              main_load  = 1'b1;
              from_skid  = 1'b1;
              skid_clear = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    pipe_slot #(.CTRL_WIDTH(CTRL_WIDTH), .DATA_WIDTH(DATA_WIDTH), .CLEAR_DATA(CLEAR_DATA)) u_main (
      .clk       (clk),
      .reset     (reset),
      .load      (main_load),
      .clear     (main_clear),
      .load_ctrl (from_skid ? skid_ctrl : in_ctrl),
      .load_data (from_skid ? skid_data : in_data),
      .valid     (out_valid),
      .ctrl      (out_ctrl),
      .data      (out_data)
    );

    pipe_slot #(.CTRL_WIDTH(CTRL_WIDTH), .DATA_WIDTH(DATA_WIDTH), .CLEAR_DATA(CLEAR_DATA)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .load      (skid_load),
      .clear     (skid_clear),
      .load_ctrl (in_ctrl),
      .load_data (in_data),
      .valid     (skid_valid),
      .ctrl      (skid_ctrl),
      .data      (skid_data)
    );
  end else begin : g_single
    logic accept, consume;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign consume  = out_valid & out_ready;

    pipe_slot #(.CTRL_WIDTH(CTRL_WIDTH), .DATA_WIDTH(DATA_WIDTH), .CLEAR_DATA(CLEAR_DATA)) u_main (
      .clk       (clk),
      .reset     (reset),
      .load      (accept),
      .clear     (flush | (consume & ~accept)),
      .load_ctrl (in_ctrl),
      .load_data (in_data),
      .valid     (out_valid),
      .ctrl      (out_ctrl),
      .data      (out_data)
    );
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench: three pipe_stage variants (skid, single, skid+clear-data)
// share one stimulus stream; each expectation is hand-computed.
module tb_pipe_stage;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [15:0] in_ctrl;
  logic [63:0] in_data;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
  logic [15:0] a_out_ctrl, b_out_ctrl, c_out_ctrl;
  logic [63:0] a_out_data, b_out_data, c_out_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage #(.SKID(1'b1), .CLEAR_DATA(1'b0)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_ctrl(a_out_ctrl), .out_data(a_out_data));

  pipe_stage #(.SKID(1'b0), .CLEAR_DATA(1'b0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_ctrl(b_out_ctrl), .out_data(b_out_data));

  pipe_stage #(.SKID(1'b1), .CLEAR_DATA(1'b1)) dut_c (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_ctrl(c_out_ctrl), .out_data(c_out_data));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] c, input logic [63:0] d);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    tick(); tick();
    check("rst_a_valid", {63'd0, a_out_valid}, 64'd0);
    check("rst_a_ctrl", {48'd0, a_out_ctrl}, 64'd0);
    check("rst_a_data", a_out_data, 64'd0);
    check("rst_a_ready", {63'd0, a_in_ready}, 64'd1);
    check("rst_b_ready", {63'd0, b_in_ready}, 64'd1);

    // Stream 1..8 with out_ready high, starting in the reset-deassert cycle.
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      push(16'(i), 64'(i * 256));
      check("strm_a_ready_pre", {63'd0, a_in_ready}, 64'd1);
      tick();
      check("strm_a_valid", {63'd0, a_out_valid}, 64'd1);
      check("strm_a_ctrl", {48'd0, a_out_ctrl}, 64'(i));
      check("strm_a_data", a_out_data, 64'(i * 256));
      check("strm_b_ctrl", {48'd0, b_out_ctrl}, 64'(i));
      $display("stream ctrl=0x%04h out_a=0x%04h out_b=0x%04h", 16'(i), a_out_ctrl, b_out_ctrl);
    end
    in_valid = 1'b0;
    tick();
    check("strm_drain_valid", {63'd0, a_out_valid}, 64'd0);
    check("strm_drain_ctrl", {48'd0, a_out_ctrl}, 64'd0);

    // Stall fill: A, B accepted, C held upstream, then drain in order.
    out_ready = 1'b0;
    push(16'h00A1, 64'hA);
    tick();
    check("fill_a_ready_after_a", {63'd0, a_in_ready}, 64'd1);
    push(16'h00B2, 64'hB);
    tick();
    check("fill_a_ready_after_b", {63'd0, a_in_ready}, 64'd0);
    check("fill_a_ctrl_a", {48'd0, a_out_ctrl}, 64'h00A1);
    push(16'h00C3, 64'hC);
    tick();
    check("fill_a_hold_ctrl", {48'd0, a_out_ctrl}, 64'h00A1);
    check("fill_a_hold_data", a_out_data, 64'hA);
    out_ready = 1'b1;
    tick();
    check("fill_a_ctrl_b", {48'd0, a_out_ctrl}, 64'h00B2);
    check("fill_a_ready_rise", {63'd0, a_in_ready}, 64'd1);
    tick();
    check("fill_a_ctrl_c", {48'd0, a_out_ctrl}, 64'h00C3);
    $display("fill drained A,B,C last_out=0x%04h", a_out_ctrl);
    in_valid = 1'b0;
    tick();
    check("fill_a_empty", {63'd0, a_out_valid}, 64'd0);

    // Flush while FULL with C presented; data hold vs clear.
    out_ready = 1'b0;
    push(16'h0A0A, 64'hDEADBEEF);
    tick();
    push(16'h0B0B, 64'h1111);
    tick();
    check("fl_a_full_ready", {63'd0, a_in_ready}, 64'd0);
    push(16'h0C0C, 64'h2222);
    flush = 1'b1;
    tick();
    check("fl_a_valid", {63'd0, a_out_valid}, 64'd0);
    check("fl_a_ctrl", {48'd0, a_out_ctrl}, 64'd0);
    check("fl_a_data_hold", a_out_data, 64'hDEADBEEF);
    check("fl_c_data_clear", c_out_data, 64'd0);
    check("fl_a_ready", {63'd0, a_in_ready}, 64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("fl_a_no_resurrect", {63'd0, a_out_valid}, 64'd0);
    tick();
    check("fl_a_still_empty", {48'd0, a_out_ctrl}, 64'd0);
    $display("flush done a_valid=%0d c_data=0x%0h", a_out_valid, c_out_data);

    // Single-slot variant: combinational ready follows out_ready.
    out_ready = 1'b0;
    push(16'h0055, 64'h55);
    tick();
    in_valid = 1'b0;
    check("s0_b_valid", {63'd0, b_out_valid}, 64'd1);
    check("s0_b_ready_low", {63'd0, b_in_ready}, 64'd0);
    out_ready = 1'b1;
    #1;
    check("s0_b_ready_high", {63'd0, b_in_ready}, 64'd1);
    out_ready = 1'b0;
    #1;
    check("s0_b_ready_low2", {63'd0, b_in_ready}, 64'd0);
    out_ready = 1'b1;
    push(16'h0061, 64'h61);
    tick();
    check("s0_b_ctrl_61", {48'd0, b_out_ctrl}, 64'h0061);
    check("s0_b_ready_bb", {63'd0, b_in_ready}, 64'd1);
    push(16'h0062, 64'h62);
    tick();
    check("s0_b_ctrl_62", {48'd0, b_out_ctrl}, 64'h0062);
    $display("single-slot back-to-back out_b=0x%04h", b_out_ctrl);

    // Reset in FULL with flush high; first push in the deassert cycle.
    out_ready = 1'b0;
    push(16'h0071, 64'h71);
    tick();
    push(16'h0072, 64'h72);
    tick();
    check("rm_a_full", {63'd0, a_in_ready}, 64'd0);
    reset = 1'b1; flush = 1'b1; in_valid = 1'b0;
    tick();
    check("rm_a_valid", {63'd0, a_out_valid}, 64'd0);
    check("rm_a_ctrl", {48'd0, a_out_ctrl}, 64'd0);
    check("rm_a_data", a_out_data, 64'd0);
    check("rm_a_ready", {63'd0, a_in_ready}, 64'd1);
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    push(16'h0081, 64'h81);
    tick();
    in_valid = 1'b0;
    check("rm_a_first_valid", {63'd0, a_out_valid}, 64'd1);
    check("rm_a_first_ctrl", {48'd0, a_out_ctrl}, 64'h0081);
    $display("reset-mid-op first push out_a=0x%04h", a_out_ctrl);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
